// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR family.
// Contents:
//   fir_state_e - FSM state encoding (idle / multiply-accumulate / output hold)
//   ch_width    - index width for a channel count, never below 1 bit
//   sat_limit   - largest positive or most negative value of a signed width
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } fir_state_e;

  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sat_limit(int unsigned width, logic negative);
    int lim;
    lim = (1 << (width - 1)) - 1;
    return negative ? (-lim - 1) : lim;
  endfunction

endpackage

// File: rtl/fir_tdm_if.sv
// Sample stream bundle for fir_tdm: valid/ready input side and valid/ready output side.
// Signals:
//   in_valid, in_ready, in                - input sample handshake and data
//   out_valid, out_ready, out, out_channel - output sample handshake, data and channel tag
// Modports:
//   master - sample source / sink side (drives in_valid, in, out_ready)
//   slave  - the filter side (drives in_ready, out_valid, out, out_channel)
interface fir_tdm_if
  import fir_pkg::*;
#(
  parameter int unsigned InputLengthBits = 8,
  parameter int unsigned NumChannels     = 2
) ();

  localparam int unsigned ChW = ch_width(NumChannels);

  logic                              in_valid;
  logic                              in_ready;
  logic signed [InputLengthBits-1:0] in;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [InputLengthBits-1:0] out;
  logic [ChW-1:0]                    out_channel;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_channel
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_channel
  );

endinterface

// File: rtl/fir_saturate.sv
// Combinational output stage: optional round-half-up, truncation of TruncBits LSBs and
// saturation of a wide signed accumulator down to OutWidth bits.
// Ports:
//   acc_i - signed accumulator value (AccWidth bits)
//   out_o - signed saturated result (OutWidth bits)
module fir_saturate
  import fir_pkg::*;
#(
  parameter int unsigned AccWidth  = 20,
  parameter int unsigned OutWidth  = 8,
  parameter int unsigned TruncBits = 10,
  parameter bit          RoundEn   = 1'b0
) (
  input  logic signed [AccWidth-1:0] acc_i,
  output logic signed [OutWidth-1:0] out_o
);

  // Index of the output MSB inside the accumulator.
  localparam int unsigned OutMsb     = OutWidth + TruncBits - 1;
  localparam int unsigned RoundShift = (TruncBits > 0) ? TruncBits - 1 : 0;
  localparam logic [AccWidth-1:0] RoundConst =
      (RoundEn && (TruncBits > 0)) ? (AccWidth'(1) << RoundShift) : '0;

  logic signed [AccWidth-1:0]   acc_r;
  logic [AccWidth-1-OutMsb:0]   top_bits;
  logic                         overflow;

  always_comb begin
    acc_r    = acc_i + $signed(RoundConst);
    // Dropped top bits plus the output MSB must all be copies of the sign.
    top_bits = acc_r[AccWidth-1:OutMsb];
    overflow = !((&top_bits) || !(|top_bits));
    if (overflow) begin
      out_o = OutWidth'(sat_limit(OutWidth, acc_r[AccWidth-1]));
    end else begin
      out_o = acc_r[OutMsb:TruncBits];
    end
  end

endmodule

// File: rtl/fir_tdm.sv
// Multi-channel time-multiplexed FIR filter. A single multiply-accumulate unit walks the
// NumTaps taps of the delay line belonging to the channel of the last accepted sample;
// channels arrive strictly interleaved 0..NumChannels-1.
// Build option: define FIR_ROUND_EN for round-half-up before truncation (default: floor).
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   bus_io - fir_tdm_if.slave: in_valid/in_ready/in, out_valid/out_ready/out/out_channel
module fir_tdm
  import fir_pkg::*;
#(
  parameter int unsigned InputLengthBits       = 8,
  parameter int unsigned CoefficientLengthBits = 10,
  parameter int unsigned AccumulatorLengthBits = 20,
  parameter int unsigned NumTaps               = 3,
  parameter int unsigned NumChannels           = 2,
  parameter int unsigned OutputTruncationBits  = 10,
  parameter logic signed [CoefficientLengthBits-1:0] Coefficients [NumTaps] =
      '{-10'sd300, 10'sd511, 10'sd300}
) (
  input logic      clk,
  input logic      rst_n,
  fir_tdm_if.slave bus_io
);

  localparam int unsigned ChW   = ch_width(NumChannels);
  localparam int unsigned TapW  = (NumTaps > 1) ? $clog2(NumTaps) : 1;
  localparam int unsigned ProdW = InputLengthBits + CoefficientLengthBits;

`ifdef FIR_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  if (NumTaps < 1) begin : gen_err_taps
    $error("fir_tdm: NumTaps must be at least 1");
  end
  if (NumChannels < 1) begin : gen_err_channels
    $error("fir_tdm: NumChannels must be at least 1");
  end
  if (AccumulatorLengthBits < InputLengthBits + OutputTruncationBits) begin : gen_err_acc
    $error("fir_tdm: accumulator too narrow for input width plus truncation");
  end

  typedef logic signed [InputLengthBits-1:0]       sample_t;
  typedef logic signed [AccumulatorLengthBits-1:0] acc_t;
  typedef logic signed [ProdW-1:0]                 prod_t;

  fir_state_e     state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  sample_t        out_q;
  logic [ChW-1:0] out_ch_q;
  logic [ChW-1:0] ch_cnt_q;   // channel expected for the next input sample
  logic [ChW-1:0] ch_q;       // channel currently being filtered
  logic [TapW-1:0] tap_q;
  acc_t           acc_q;
  sample_t        line_q [NumChannels][NumTaps];

  prod_t   prod;
  acc_t    acc_sum;
  sample_t sat_out;
  logic    last_tap;

  always_comb begin
    prod     = prod_t'(line_q[ch_q][tap_q]) * prod_t'(Coefficients[tap_q]);
    acc_sum  = acc_q + acc_t'(prod);
    last_tap = (tap_q == TapW'(NumTaps - 1));
  end

  // Fed with the running sum so the final tap's product lands in the output register directly.
  fir_saturate #(
    .AccWidth  (AccumulatorLengthBits),
    .OutWidth  (InputLengthBits),
    .TruncBits (OutputTruncationBits),
    .RoundEn   (RoundEn)
  ) u_saturate (
    .acc_i (acc_sum),
    .out_o (sat_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
      ch_cnt_q    <= '0;
      ch_q        <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        for (int k = 0; k < NumTaps; k++) begin
          line_q[c][k] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            for (int k = NumTaps - 1; k > 0; k--) begin
              line_q[ch_cnt_q][k] <= line_q[ch_cnt_q][k-1];
            end
            line_q[ch_cnt_q][0] <= bus_io.in;
            ch_q       <= ch_cnt_q;
            ch_cnt_q   <= (ch_cnt_q == ChW'(NumChannels - 1)) ? '0 : ch_cnt_q + ChW'(1);
            acc_q      <= '0;
            tap_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          tap_q <= tap_q + TapW'(1);
          if (last_tap) begin
            out_q       <= sat_out;
            out_ch_q    <= ch_q;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end
        end
        StOut: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.in_ready    = in_ready_q;
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.out         = out_q;
  assign bus_io.out_channel = out_ch_q;

endmodule
